ctrl_pipe: RTL and testbench

//  - Parametrised control-signal pipeline for the pipelined core; generalises the fixed D->E->M->W control registers.
//  - Carries a WIDTH-bit control word plus a valid bit through STAGES registers.
//  - Supports per-stage stall and flush, automatic bubble insertion, and condition-kill of selected bits at one stage.

---
 rtl/ctrl_pipe_pkg.sv | 56 +++++
 rtl/ctrl_pipe_if.sv | 62 ++++++
 rtl/ctrl_pipe_stage.sv | 61 ++++++
 rtl/ctrl_pipe.sv | 140 ++++++++++++++
 tb/tb_ctrl_pipe.sv | 366 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pipe_pkg.sv
// -----------------------------------------------------------------------------
// ctrl_pipe_pkg
// Shared definitions for the control-signal pipeline:
//   - default control-word width and the control bit-index map
//   - default kill mask built from that map (PCSrc / RegWrite / MemWrite)
//   - stage index names for the classic D/E/M/W core
//   - per-stage next-state select encoding and its priority function
// Optional feature macro used by the design: CTRL_PIPE_PERF_EN.
// -----------------------------------------------------------------------------
package ctrl_pipe_pkg;

  // Default geometry.
  localparam int CTRL_WIDTH  = 27;
  localparam int CTRL_STAGES = 4;

  // Control-word bit map.
  localparam int BIT_PCSRC      = 0;
  localparam int BIT_REGW       = 1;
  localparam int BIT_MEMTOREG   = 2;
  localparam int BIT_MEMW       = 3;
  localparam int BIT_ALUCTL_LSB = 4;
  localparam int BIT_ALUCTL_MSB = 7;
  localparam int BIT_ALUSRC     = 8;
  localparam int BIT_REGDST     = 9;
  localparam int BIT_BRANCH     = 10;

  // Bits that must be suppressed when a conditional instruction fails:
  // anything that redirects the PC or commits architectural state.
  localparam logic [CTRL_WIDTH-1:0] CTRL_KILL_MASK =
    CTRL_WIDTH'((1 << BIT_PCSRC) | (1 << BIT_REGW) | (1 << BIT_MEMW));

  // Stage index names.
  localparam int ST_D = 0;
  localparam int ST_E = 1;
  localparam int ST_M = 2;
  localparam int ST_W = 3;

  // What a stage register does on the next edge.
  typedef enum logic [1:0] {
    SEL_LOAD   = 2'd0,  // take the word from the previous stage / input
    SEL_BUBBLE = 2'd1,  // previous stage is held: insert an empty slot
    SEL_HOLD   = 2'd2,  // this stage (or a later one) is stalled
    SEL_CLEAR  = 2'd3   // flushed
  } stage_sel_e;

  // Priority: flush beats hold beats bubble beats load.
  function automatic stage_sel_e stage_select(input logic flush,
                                              input logic hold,
                                              input logic hold_prev);
    if (flush)     return SEL_CLEAR;
    if (hold)      return SEL_HOLD;
    if (hold_prev) return SEL_BUBBLE;
    return SEL_LOAD;
  endfunction

endpackage

// File: rtl/ctrl_pipe_if.sv
// -----------------------------------------------------------------------------
// ctrl_pipe_if
// Bundles the control pipeline's handshake and observation signals.
//   master : upstream/decode side - drives in_valid, in_ctrl, stall, flush,
//            cond_ok; observes stage_valid, stage_ctrl, out_valid, out_ctrl,
//            in_ready (and perf_* when CTRL_PIPE_PERF_EN is defined).
//   slave  : the pipeline itself (directions reversed).
// Signals:
//   in_valid/in_ctrl   word offered to stage 0
//   stall[i]/flush[i]  per-stage hold / invalidate
//   cond_ok            condition result for the word leaving the kill stage
//   stage_valid/ctrl   every stage register, stage i at [i*WIDTH +: WIDTH]
//   out_valid/out_ctrl last stage
//   in_ready           stage 0 accepts this cycle
// Optional macro: CTRL_PIPE_PERF_EN adds perf_bubbles/perf_flushes/perf_kills.
// -----------------------------------------------------------------------------
interface ctrl_pipe_if
  import ctrl_pipe_pkg::*;
#(
  parameter int WIDTH  = CTRL_WIDTH,
  parameter int STAGES = CTRL_STAGES
) ();

  logic                      in_valid;
  logic [WIDTH-1:0]          in_ctrl;
  logic [STAGES-1:0]         stall;
  logic [STAGES-1:0]         flush;
  logic                      cond_ok;
  logic [STAGES-1:0]         stage_valid;
  logic [STAGES*WIDTH-1:0]   stage_ctrl;
  logic                      out_valid;
  logic [WIDTH-1:0]          out_ctrl;
  logic                      in_ready;
`ifdef CTRL_PIPE_PERF_EN
  logic [31:0]               perf_bubbles;
  logic [31:0]               perf_flushes;
  logic [31:0]               perf_kills;

  modport master (
    output in_valid, in_ctrl, stall, flush, cond_ok,
    input  stage_valid, stage_ctrl, out_valid, out_ctrl, in_ready,
    input  perf_bubbles, perf_flushes, perf_kills
  );

  modport slave (
    input  in_valid, in_ctrl, stall, flush, cond_ok,
    output stage_valid, stage_ctrl, out_valid, out_ctrl, in_ready,
    output perf_bubbles, perf_flushes, perf_kills
  );
`else
  modport master (
    output in_valid, in_ctrl, stall, flush, cond_ok,
    input  stage_valid, stage_ctrl, out_valid, out_ctrl, in_ready
  );

  modport slave (
    input  in_valid, in_ctrl, stall, flush, cond_ok,
    output stage_valid, stage_ctrl, out_valid, out_ctrl, in_ready
  );
`endif

endinterface

// File: rtl/ctrl_pipe_stage.sv
// -----------------------------------------------------------------------------
// ctrl_pipe_stage
// One pipeline register: a valid bit plus a WIDTH-bit control word.
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset (clears valid and word)
//   i_sel    next-state select: load / bubble / hold / clear
//   i_valid  incoming valid (used on load)
//   i_ctrl   incoming word (used on load)
//   o_valid  registered valid
//   o_ctrl   registered word; always zero while o_valid is zero
// -----------------------------------------------------------------------------
module ctrl_pipe_stage
  import ctrl_pipe_pkg::*;
#(
  parameter int WIDTH = CTRL_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  stage_sel_e       i_sel,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_ctrl,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_ctrl
);

  logic             r_valid;
  logic [WIDTH-1:0] r_ctrl;

  // NOTE: reset is asynchronous (in the sensitivity list) so the whole pipe
  // empties the instant rst_n falls, without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every stage
      // samples its neighbour's pre-edge value; blocking here would let a
      // word race through several stages in one edge.
      case (i_sel)
        SEL_CLEAR, SEL_BUBBLE: begin
          r_valid <= 1'b0;
          r_ctrl  <= '0;
        end
        SEL_LOAD: begin
          r_valid <= i_valid;
          // An invalid slot never carries nonzero control downstream.
          r_ctrl  <= i_valid ? i_ctrl : '0;
        end
        default: begin
          r_valid <= r_valid;
          r_ctrl  <= r_ctrl;
        end
      endcase
    end
  end

  assign o_valid = r_valid;
  assign o_ctrl  = r_ctrl;

endmodule

// File: rtl/ctrl_pipe.sv
// -----------------------------------------------------------------------------
// ctrl_pipe
// Parametrised control-signal pipeline (generalises the fixed D->E->M->W
// control registers). A WIDTH-bit control word plus a valid bit travel through
// STAGES registers with per-stage stall and flush, automatic bubble insertion
// behind a stall, and condition-kill of KILL_MASK bits as the word leaves
// KILL_STAGE.
// Parameters:
//   WIDTH       control word width
//   STAGES      number of stage registers (>= 2)
//   KILL_STAGE  stage whose outgoing word is gated by cond_ok (0..STAGES-2)
//   KILL_MASK   bits cleared on that transfer when cond_ok is 0
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    ctrl_pipe_if.slave (inputs, per-stage view, last stage, in_ready)
// Optional macro: CTRL_PIPE_PERF_EN adds 32-bit wrapping counters
//   perf_bubbles (edges the last stage takes a bubble), perf_flushes (edges
//   on which any flush hits a valid stage), perf_kills (valid words leaving
//   KILL_STAGE with cond_ok=0 and a KILL_MASK bit set).
// -----------------------------------------------------------------------------
module ctrl_pipe
  import ctrl_pipe_pkg::*;
#(
  parameter int               WIDTH      = CTRL_WIDTH,
  parameter int               STAGES     = CTRL_STAGES,
  parameter int               KILL_STAGE = ST_E,
  parameter logic [WIDTH-1:0] KILL_MASK  = WIDTH'(CTRL_KILL_MASK)
) (
  input  logic       clk,
  input  logic       reset,
  ctrl_pipe_if.slave bus
);

  logic [STAGES-1:0]       w_hold;
  stage_sel_e              w_sel       [STAGES];
  logic                    w_src_valid [STAGES];
  logic [WIDTH-1:0]        w_src_ctrl  [STAGES];
  logic                    w_q_valid   [STAGES];
  logic [WIDTH-1:0]        w_q_ctrl    [STAGES];
  logic [STAGES-1:0]       w_stage_valid;
  logic [STAGES*WIDTH-1:0] w_stage_ctrl;
  logic [WIDTH-1:0]        w_kill_gate;

  // hold[i] is the OR of stall[j] for all j >= i: a stall backs up into
  // every earlier stage. Derived from stall only, so a flushed-and-stalled
  // stage still holds the stages in front of it.
  // NOTE: every always_comb output is given a value before any branching or
  // looping so no path can leave it unassigned and infer a latch.
  always_comb begin
    w_hold = '0;
    w_hold[STAGES-1] = bus.stall[STAGES-1];
    for (int i = STAGES - 2; i >= 0; i--) begin
      w_hold[i] = bus.stall[i] | w_hold[i+1];
    end
  end

  // Bits to clear on the kill transfer: KILL_MASK when the condition failed.
  assign w_kill_gate = KILL_MASK & ~{WIDTH{bus.cond_ok}};

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    if (g == 0) begin : g_head
      assign w_src_valid[g] = bus.in_valid;
      assign w_src_ctrl[g]  = bus.in_ctrl;
      assign w_sel[g]       = stage_select(bus.flush[g], w_hold[g], 1'b0);
    end else begin : g_body
      assign w_src_valid[g] = w_q_valid[g-1];
      if (g - 1 == KILL_STAGE) begin : g_kill
        // Only the moving word is gated; a held or invalid kill stage makes
        // cond_ok irrelevant because nothing (or only zeros) moves.
        assign w_src_ctrl[g] = w_q_ctrl[g-1] & ~w_kill_gate;
      end else begin : g_pass
        assign w_src_ctrl[g] = w_q_ctrl[g-1];
      end
      assign w_sel[g] = stage_select(bus.flush[g], w_hold[g], w_hold[g-1]);
    end

    ctrl_pipe_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk     (clk),
      .rst_n   (reset),
      .i_sel   (w_sel[g]),
      .i_valid (w_src_valid[g]),
      .i_ctrl  (w_src_ctrl[g]),
      .o_valid (w_q_valid[g]),
      .o_ctrl  (w_q_ctrl[g])
    );
  end

  // Flatten the per-stage view for observation.
  always_comb begin
    w_stage_valid = '0;
    w_stage_ctrl  = '0;
    for (int i = 0; i < STAGES; i++) begin
      w_stage_valid[i]              = w_q_valid[i];
      w_stage_ctrl[i*WIDTH +: WIDTH] = w_q_ctrl[i];
    end
  end

  assign bus.stage_valid = w_stage_valid;
  assign bus.stage_ctrl  = w_stage_ctrl;
  assign bus.out_valid   = w_q_valid[STAGES-1];
  assign bus.out_ctrl    = w_q_ctrl[STAGES-1];
  // Gated by reset so every output reads 0 while reset is held.
  assign bus.in_ready    = reset & ~w_hold[0];

`ifdef CTRL_PIPE_PERF_EN
  logic [31:0] r_perf_bubbles;
  logic [31:0] r_perf_flushes;
  logic [31:0] r_perf_kills;
  logic        w_ev_bubble;
  logic        w_ev_flush;
  logic        w_ev_kill;

  assign w_ev_bubble = (w_sel[STAGES-1] == SEL_BUBBLE);
  assign w_ev_flush  = |(bus.flush & w_stage_valid);
  assign w_ev_kill   = (w_sel[KILL_STAGE+1] == SEL_LOAD) &&
                       w_q_valid[KILL_STAGE] && !bus.cond_ok &&
                       (|(w_q_ctrl[KILL_STAGE] & KILL_MASK));

  // Counters wrap naturally at 2^32.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_perf_bubbles <= '0;
      r_perf_flushes <= '0;
      r_perf_kills   <= '0;
    end else begin
      if (w_ev_bubble) r_perf_bubbles <= r_perf_bubbles + 32'd1;
      if (w_ev_flush)  r_perf_flushes <= r_perf_flushes + 32'd1;
      if (w_ev_kill)   r_perf_kills   <= r_perf_kills + 32'd1;
    end
  end

  assign bus.perf_bubbles = r_perf_bubbles;
  assign bus.perf_flushes = r_perf_flushes;
  assign bus.perf_kills   = r_perf_kills;
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// -----------------------------------------------------------------------------
// tb_ctrl_pipe
// Self-checking bench for ctrl_pipe (default configuration: WIDTH=27,
// STAGES=4, KILL_STAGE=1, KILL_MASK='hB). A behavioural model holds the
// expected contents of each stage as plain arrays and advances them from the
// pipeline rules once per edge. Directed scenarios plus a randomized run.
// -----------------------------------------------------------------------------
module tb_ctrl_pipe;
  import ctrl_pipe_pkg::*;

  localparam int               W  = 27;
  localparam int               S  = 4;
  localparam int               KS = 1;
  localparam logic [W-1:0]     KM = 27'hB;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  ctrl_pipe_if #(.WIDTH(W), .STAGES(S)) bus ();

  ctrl_pipe #(
    .WIDTH      (W),
    .STAGES     (S),
    .KILL_STAGE (KS),
    .KILL_MASK  (KM)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: expected content of each stage register.
  logic         m_valid [S];
  logic [W-1:0] m_ctrl  [S];

  function automatic logic [S*W-1:0] model_ctrl_flat();
    logic [S*W-1:0] f;
    f = '0;
    for (int i = 0; i < S; i++) f[i*W +: W] = m_ctrl[i];
    return f;
  endfunction

  function automatic logic [S-1:0] model_valid_flat();
    logic [S-1:0] f;
    f = '0;
    for (int i = 0; i < S; i++) f[i] = m_valid[i];
    return f;
  endfunction

  function automatic logic [W-1:0] rand_word();
    return W'($urandom_range(1, (1 << W) - 1));
  endfunction

  task automatic model_clear();
    for (int i = 0; i < S; i++) begin
      m_valid[i] = 1'b0;
      m_ctrl[i]  = '0;
    end
  endtask

  task automatic drive(input logic v, input logic [W-1:0] c,
                       input logic [S-1:0] st, input logic [S-1:0] fl,
                       input logic ok);
    bus.in_valid = v;
    bus.in_ctrl  = c;
    bus.stall    = st;
    bus.flush    = fl;
    bus.cond_ok  = ok;
  endtask

  // One clock edge: compute the expected next stage contents from the
  // current model and the applied inputs, clock, then commit.
  task automatic advance();
    logic         nv [S];
    logic [W-1:0] nc [S];
    logic         held, prev_held;
    for (int i = 0; i < S; i++) begin
      held      = ((bus.stall >> i) != '0);
      prev_held = (i > 0) && ((bus.stall >> (i - 1)) != '0);
      if (bus.flush[i]) begin
        nv[i] = 1'b0; nc[i] = '0;
      end else if (held) begin
        nv[i] = m_valid[i]; nc[i] = m_ctrl[i];
      end else if (prev_held) begin
        nv[i] = 1'b0; nc[i] = '0;
      end else if (i == 0) begin
        nv[i] = bus.in_valid;
        nc[i] = bus.in_valid ? bus.in_ctrl : '0;
      end else begin
        nv[i] = m_valid[i-1];
        nc[i] = m_ctrl[i-1];
        if (i - 1 == KS && !bus.cond_ok) nc[i] = m_ctrl[i-1] & ~KM;
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < S; i++) begin
      m_valid[i] = nv[i];
      m_ctrl[i]  = nc[i];
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(1'b0, '0, '0, '0, 1'b1);
    model_clear();
    #12;
    n_checks++;
    if (bus.stage_valid !== '0) begin
      n_errors++; $display("FAIL reset_stage_valid: got %h expected 0", bus.stage_valid);
    end
    n_checks++;
    if (bus.stage_ctrl !== '0) begin
      n_errors++; $display("FAIL reset_stage_ctrl: got %h expected 0", bus.stage_ctrl);
    end
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_ctrl !== '0) begin
      n_errors++; $display("FAIL reset_out: got %b/%h expected 0/0", bus.out_valid, bus.out_ctrl);
    end
    n_checks++;
    if (bus.in_ready !== 1'b0) begin
      n_errors++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_errors++; $display("FAIL release_in_ready: got %b expected 1", bus.in_ready);
    end
  endtask

  task automatic test_streaming();
    for (int k = 1; k <= 7; k++) begin
      drive(k <= 4, W'(k), '0, '0, 1'b1);
      advance();
      if (k >= 4) begin
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_ctrl !== W'(k - 3)) begin
          n_errors++;
          $display("FAIL stream_out edge %0d: got %b/%h expected 1/%h", k,
                   bus.out_valid, bus.out_ctrl, W'(k - 3));
        end
      end
      n_checks++;
      if (bus.stage_ctrl !== model_ctrl_flat()) begin
        n_errors++;
        $display("FAIL stream_stages edge %0d: got %h expected %h", k,
                 bus.stage_ctrl, model_ctrl_flat());
      end
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] w [4];
    logic [W-1:0] got [$];
    for (int i = 0; i < 4; i++) w[i] = rand_word();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, w[2-i], '0, '0, 1'b1);  // words enter oldest first: w[2], w[1], w[0]
      advance();
      if (bus.out_valid) got.push_back(bus.out_ctrl);
    end
    // In flight: stage0=w[0], stage1=w[1], stage2=w[2]. Offer w[3] while stalled.
    for (int e = 0; e < 2; e++) begin
      drive(1'b1, w[3], S'(2), '0, 1'b1);
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b0) begin
        n_errors++; $display("FAIL stall_in_ready cycle %0d: got %b expected 0", e, bus.in_ready);
      end
      advance();
      if (bus.out_valid) got.push_back(bus.out_ctrl);
      n_checks++;
      if (bus.stage_valid[2] !== 1'b0 || bus.stage_ctrl[2*W +: W] !== '0) begin
        n_errors++;
        $display("FAIL stall_bubble cycle %0d: got %b/%h expected 0/0", e,
                 bus.stage_valid[2], bus.stage_ctrl[2*W +: W]);
      end
      n_checks++;
      if (bus.stage_valid[1:0] !== 2'b11 || bus.stage_ctrl[0 +: W] !== w[0] ||
          bus.stage_ctrl[W +: W] !== w[1]) begin
        n_errors++;
        $display("FAIL stall_retain cycle %0d: got %b %h %h expected 11 %h %h", e,
                 bus.stage_valid[1:0], bus.stage_ctrl[0 +: W], bus.stage_ctrl[W +: W],
                 w[0], w[1]);
      end
    end
    drive(1'b1, w[3], '0, '0, 1'b1);
    advance();
    if (bus.out_valid) got.push_back(bus.out_ctrl);
    for (int e = 0; e < 5; e++) begin
      drive(1'b0, '0, '0, '0, 1'b1);
      advance();
      if (bus.out_valid) got.push_back(bus.out_ctrl);
    end
    n_checks++;
    if (got.size() != 4) begin
      n_errors++; $display("FAIL stall_count: got %0d words expected 4", got.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (got[i] !== w[(i < 3) ? 2 - i : 3]) begin
          n_errors++;
          $display("FAIL stall_order word %0d: got %h expected %h", i, got[i],
                   w[(i < 3) ? 2 - i : 3]);
        end
      end
    end
  endtask

  task automatic test_flush_over_stall();
    logic [W-1:0] x1, x2, y;
    x1 = rand_word(); x2 = rand_word(); y = rand_word();
    drive(1'b1, x1, '0, '0, 1'b1); advance();
    drive(1'b1, x2, '0, '0, 1'b1); advance();
    drive(1'b1, y, S'(1), S'(1), 1'b1);
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b0) begin
      n_errors++; $display("FAIL flush_in_ready: got %b expected 0", bus.in_ready);
    end
    advance();
    n_checks++;
    if (bus.stage_valid[1:0] !== 2'b00 || bus.stage_ctrl[0 +: 2*W] !== '0) begin
      n_errors++;
      $display("FAIL flush_stage01: got %b %h expected 00 0", bus.stage_valid[1:0],
               bus.stage_ctrl[0 +: 2*W]);
    end
    n_checks++;
    if (bus.stage_valid[2] !== 1'b1 || bus.stage_ctrl[2*W +: W] !== x1) begin
      n_errors++;
      $display("FAIL flush_stage2: got %b/%h expected 1/%h", bus.stage_valid[2],
               bus.stage_ctrl[2*W +: W], x1);
    end
    for (int e = 0; e < 4; e++) begin
      drive(1'b0, '0, '0, '0, 1'b1);
      advance();
    end
  endtask

  task automatic test_kill();
    logic [W-1:0] word, exp;
    logic         ok;
    for (int r = 0; r < 6; r++) begin
      if (r < 2) begin
        word = 27'h1F; ok = (r == 1);
        exp  = ok ? 27'h1F : 27'h14;
      end else begin
        word = rand_word(); ok = 1'($urandom_range(0, 1));
        exp  = ok ? word : (word & ~KM);
      end
      drive(1'b1, word, '0, '0, 1'b1); advance();
      drive(1'b0, '0, '0, '0, 1'b1);   advance();
      drive(1'b0, '0, '0, '0, ok);     advance();
      n_checks++;
      if (bus.stage_valid[2] !== 1'b1 || bus.stage_ctrl[2*W +: W] !== exp) begin
        n_errors++;
        $display("FAIL kill round %0d cond_ok=%b: got %b/%h expected 1/%h", r, ok,
                 bus.stage_valid[2], bus.stage_ctrl[2*W +: W], exp);
      end
      drive(1'b0, '0, '0, '0, 1'b1); advance();
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_ctrl !== exp) begin
        n_errors++;
        $display("FAIL kill_out round %0d: got %b/%h expected 1/%h", r,
                 bus.out_valid, bus.out_ctrl, exp);
      end
    end
    drive(1'b0, '0, '0, '0, 1'b1); advance();
  endtask

  task automatic test_reset_midstream();
    logic [W-1:0] z;
    for (int i = 0; i < S; i++) begin
      drive(1'b1, rand_word(), '0, '0, 1'b1);
      advance();
    end
    n_checks++;
    if (bus.stage_valid !== {S{1'b1}}) begin
      n_errors++; $display("FAIL midreset_full: got %b expected all 1", bus.stage_valid);
    end
    #3;
    reset = 1'b0;
    model_clear();
    #1;
    n_checks++;
    if (bus.stage_valid !== '0 || bus.stage_ctrl !== '0 || bus.out_valid !== 1'b0 ||
        bus.out_ctrl !== '0 || bus.in_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL midreset_clear: got v=%b c=%h ov=%b oc=%h rdy=%b expected all 0",
               bus.stage_valid, bus.stage_ctrl, bus.out_valid, bus.out_ctrl, bus.in_ready);
    end
    @(negedge clk);
    reset = 1'b1;
    z = rand_word();
    drive(1'b1, z, '0, '0, 1'b1);
    for (int e = 1; e <= S; e++) begin
      advance();
      drive(1'b0, '0, '0, '0, 1'b1);
      n_checks++;
      if (e < S && bus.out_valid !== 1'b0) begin
        n_errors++; $display("FAIL midreset_early edge %0d: got out_valid=%b expected 0", e, bus.out_valid);
      end else if (e == S && (bus.out_valid !== 1'b1 || bus.out_ctrl !== z)) begin
        n_errors++;
        $display("FAIL midreset_latency: got %b/%h expected 1/%h", bus.out_valid, bus.out_ctrl, z);
      end
    end
  endtask

  task automatic test_random();
    logic [S-1:0] st, fl;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < S; i++) begin
        st[i] = ($urandom_range(0, 5) == 0);
        fl[i] = ($urandom_range(0, 9) == 0);
      end
      drive(($urandom_range(0, 3) != 0), W'($urandom), st, fl, 1'($urandom_range(0, 1)));
      #1;
      n_checks++;
      if (bus.in_ready !== (st == '0)) begin
        n_errors++; $display("FAIL rand_in_ready cycle %0d: got %b expected %b", n, bus.in_ready, (st == '0));
      end
      advance();
      n_checks++;
      if (bus.stage_valid !== model_valid_flat()) begin
        n_errors++;
        $display("FAIL rand_valid cycle %0d: got %b expected %b", n, bus.stage_valid, model_valid_flat());
      end
      n_checks++;
      if (bus.stage_ctrl !== model_ctrl_flat()) begin
        n_errors++;
        $display("FAIL rand_ctrl cycle %0d: got %h expected %h", n, bus.stage_ctrl, model_ctrl_flat());
      end
      n_checks++;
      if (bus.out_valid !== m_valid[S-1] || bus.out_ctrl !== m_ctrl[S-1]) begin
        n_errors++;
        $display("FAIL rand_out cycle %0d: got %b/%h expected %b/%h", n, bus.out_valid,
                 bus.out_ctrl, m_valid[S-1], m_ctrl[S-1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_stall();
    test_flush_over_stall();
    test_kill();
    test_reset_midstream();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
